// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor family.
// Provides saturating-counter helpers that work for any counter width
// up to CTR_MAX_W, the weak-not-taken reset value, and the width of
// the mispredict performance counter.
package bp_pkg;

  localparam int MISPRED_CNT_BITS = 16;
  localparam int CTR_MAX_W        = 4;

  // Counters of every legal width are carried in this word and cut down
  // to their real width at the call site.
  typedef logic [CTR_MAX_W-1:0] ctr_word_t;

  function automatic ctr_word_t ctr_weak_nt(input int unsigned ctr_bits);
    return ctr_word_t'((32'd1 << (ctr_bits - 32'd1)) - 32'd1);
  endfunction

  function automatic ctr_word_t ctr_max(input int unsigned ctr_bits);
    return ctr_word_t'((32'd1 << ctr_bits) - 32'd1);
  endfunction

  function automatic ctr_word_t sat_inc(input ctr_word_t v, input int unsigned ctr_bits);
    return (v >= ctr_max(ctr_bits)) ? ctr_max(ctr_bits) : v + ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t sat_dec(input ctr_word_t v, input int unsigned ctr_bits);
    ctr_word_t unused_width;
    unused_width = ctr_word_t'(ctr_bits);
    return (v == '0) ? '0 : v - ctr_word_t'(1) + (unused_width & '0);
  endfunction

endpackage

// File: rtl/bp_index_hash.sv
// Table index generation for the predictor family.
// Bimodal (GHR_BITS == 0): idx = pc[INDEX_BITS+1:2]; the ghr port is ignored.
// Gshare  (GHR_BITS  > 0): idx = pc[INDEX_BITS+1:2] ^ zero-extended ghr.
// Ports:
//   pc  - fetch PC
//   ghr - global history (width 1 and unused in bimodal mode)
//   idx - table index
module bp_index_hash #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 0,
  parameter int PC_BITS    = 32,
  parameter int GHR_W      = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic [PC_BITS-1:0]    pc,
  input  logic [GHR_W-1:0]      ghr,
  output logic [INDEX_BITS-1:0] idx
);

  // Low two PC bits are the instruction byte offset and never index.
  if (GHR_BITS == 0) begin : g_bimodal
    assign idx = pc[INDEX_BITS+1:2];
  end else begin : g_gshare
    assign idx = pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  end

  logic unused_bits;
  assign unused_bits = ^{pc, ghr};

endmodule

// File: rtl/branch_predictor_table.sv
// Table of 2^INDEX_BITS saturating direction counters with optional
// gshare history, a zero-latency lookup and a one-cycle write-back.
// Ports:
//   clk, reset (async, active-low)
//   lookup_pc                       - fetch PC
//   predict_taken, predict_index    - combinational prediction and index used
//   update_valid/index/taken/mispredict - resolved branch from execute
//   mispredict_count                - saturating count of mispredicted updates
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int PC_BITS    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PC_BITS-1:0]          lookup_pc,
  output logic                        predict_taken,
  output logic [INDEX_BITS-1:0]       predict_index,
  input  logic                        update_valid,
  input  logic [INDEX_BITS-1:0]       update_index,
  input  logic                        update_taken,
  input  logic                        update_mispredict,
  output logic [MISPRED_CNT_BITS-1:0] mispredict_count
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;
  localparam int GHR_W       = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  logic [CTR_BITS-1:0]         ctr_q [NUM_ENTRIES];
  logic [CTR_BITS-1:0]         ctr_d [NUM_ENTRIES];
  logic [MISPRED_CNT_BITS-1:0] mispredict_count_q, mispredict_count_d;
  logic [GHR_W-1:0]            ghr_cur;
  logic [INDEX_BITS-1:0]       lookup_idx;

  bp_index_hash #(
    .INDEX_BITS (INDEX_BITS),
    .GHR_BITS   (GHR_BITS),
    .PC_BITS    (PC_BITS),
    .GHR_W      (GHR_W)
  ) u_hash (
    .pc  (lookup_pc),
    .ghr (ghr_cur),
    .idx (lookup_idx)
  );

  // Lookup reads the registered array, so a same-cycle update to the same
  // entry is only visible from the following cycle.
  assign predict_index    = lookup_idx;
  assign predict_taken    = ctr_q[lookup_idx][CTR_BITS-1];
  assign mispredict_count = mispredict_count_q;

  always_comb begin
    ctr_d = ctr_q;
    if (update_valid) begin
      if (update_taken) begin
        ctr_d[update_index] = CTR_BITS'(sat_inc(ctr_word_t'(ctr_q[update_index]), CTR_BITS));
      end else begin
        ctr_d[update_index] = CTR_BITS'(sat_dec(ctr_word_t'(ctr_q[update_index]), CTR_BITS));
      end
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (update_valid && update_mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + MISPRED_CNT_BITS'(1);
    end
  end

  // Every entry needs the async reset, so the table stays a flop array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ctr_q[i] <= WEAK_NT;
      end
      mispredict_count_q <= '0;
    end else begin
      ctr_q              <= ctr_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // History is non-speculative: it shifts only on resolved branches.
    // Truncating the concatenation drops the oldest bit and also covers
    // the single-bit history case.
    always_comb begin
      ghr_d = ghr_q;
      if (update_valid) begin
        ghr_d = GHR_BITS'({ghr_q, update_taken});
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ghr_q <= '0;
      end else begin
        ghr_q <= ghr_d;
      end
    end

    assign ghr_cur = ghr_q;
  end else begin : g_no_ghr
    assign ghr_cur = '0;
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;
  logic        pt_a, pt_b;
  logic [5:0]  pi_a, pi_b;
  logic [15:0] mc_a, mc_b;

  always #5 clk = ~clk;

  // A: default bimodal, 2-bit counters. B: gshare with 4-bit history, 3-bit counters.
  branch_predictor_table dut_a (
    .clk(clk), .reset(rst_a), .lookup_pc(lookup_pc),
    .predict_taken(pt_a), .predict_index(pi_a),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .mispredict_count(mc_a)
  );

  branch_predictor_table #(.INDEX_BITS(6), .CTR_BITS(3), .GHR_BITS(4), .PC_BITS(32)) dut_b (
    .clk(clk), .reset(rst_b), .lookup_pc(lookup_pc),
    .predict_taken(pt_b), .predict_index(pi_b),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .mispredict_count(mc_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  // Reference state
  int mA[64];
  int mB[64];
  int ghrB;
  int cntA, cntB;

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic check_next(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check_next(obs);
  endtask

  function automatic int idx_b(input logic [31:0] pc);
    return int'(pc[7:2]) ^ ghrB;
  endfunction

  task automatic model_reset_a();
    for (int i = 0; i < 64; i++) mA[i] = 1;
    cntA = 0;
  endtask

  task automatic model_reset_b();
    for (int i = 0; i < 64; i++) mB[i] = 3;
    ghrB = 0;
    cntB = 0;
  endtask

  task automatic model_update(input logic uv, input logic [5:0] ui, input logic ut, input logic um);
    if (uv) begin
      if (ut) begin
        mA[ui] = (mA[ui] < 3) ? mA[ui] + 1 : 3;
        mB[ui] = (mB[ui] < 7) ? mB[ui] + 1 : 7;
      end else begin
        mA[ui] = (mA[ui] > 0) ? mA[ui] - 1 : 0;
        mB[ui] = (mB[ui] > 0) ? mB[ui] - 1 : 0;
      end
      ghrB = ((ghrB << 1) | int'(ut)) & 15;
      if (um) begin
        cntA = (cntA < 65535) ? cntA + 1 : 65535;
        cntB = (cntB < 65535) ? cntB + 1 : 65535;
      end
    end
  endtask

  // One cycle: drive at negedge, check pre-edge outputs, apply the edge to the model.
  // ea/eb/ei >= 0 add fixed expectations for pt_a / pt_b / pi_b.
  task automatic step(input logic [31:0] pc, input logic uv, input logic [5:0] ui,
                      input logic ut, input logic um, input int ea, input int eb, input int ei);
    @(negedge clk);
    lookup_pc         = pc;
    update_valid      = uv;
    update_index      = ui;
    update_taken      = ut;
    update_mispredict = um;
    expect_val("pt_a", 32'(mA[pc[7:2]] >= 2));
    expect_val("pi_a", 32'(pc[7:2]));
    expect_val("pt_b", 32'(mB[idx_b(pc)] >= 4));
    expect_val("pi_b", 32'(idx_b(pc)));
    expect_val("mc_a", 32'(cntA));
    expect_val("mc_b", 32'(cntB));
    if (ea >= 0) expect_val("pt_a_plan", 32'(ea));
    if (eb >= 0) expect_val("pt_b_plan", 32'(eb));
    if (ei >= 0) expect_val("pi_b_plan", 32'(ei));
    #1;
    check_next(32'(pt_a));
    check_next(32'(pi_a));
    check_next(32'(pt_b));
    check_next(32'(pi_b));
    check_next(32'(mc_a));
    check_next(32'(mc_b));
    if (ea >= 0) check_next(32'(pt_a));
    if (eb >= 0) check_next(32'(pt_b));
    if (ei >= 0) check_next(32'(pi_b));
    @(posedge clk);
    model_update(uv, ui, ut, um);
  endtask

  // Reset both instances between edges and check the reset outputs asynchronously.
  task automatic reset_both();
    @(negedge clk);
    update_valid = 1'b0;
    lookup_pc    = 32'h14;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_reset_a();
    model_reset_b();
    #1;
    chk("rst_pt_a", 32'(pt_a), 32'd0);
    chk("rst_pi_a", 32'(pi_a), 32'h05);
    chk("rst_mc_a", 32'(mc_a), 32'd0);
    chk("rst_pt_b", 32'(pt_b), 32'd0);
    chk("rst_mc_b", 32'(mc_b), 32'd0);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    rst_a = 1'b1;
    rst_b = 1'b1;
    lookup_pc = 32'h14;
    update_valid = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    update_mispredict = 1'b0;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_reset_a();
    model_reset_b();
    #2;
    chk("init_pt_a", 32'(pt_a), 32'd0);
    chk("init_pi_a", 32'(pi_a), 32'h05);
    chk("init_mc_a", 32'(mc_a), 32'd0);
    chk("init_mc_b", 32'(mc_b), 32'd0);
    @(negedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset state across several PCs (low two bits must not affect the index)
    step(32'h0000_0014, 1'b0, 6'd0, 1'b0, 1'b0, 0, 0, 5);
    step(32'hFFFF_FFFF, 1'b0, 6'd0, 1'b0, 1'b0, 0, 0, 63);
    step(32'h0000_0103, 1'b0, 6'd0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step($urandom, 1'b0, 6'd0, 1'b0, 1'b0, 0, 0, -1);
    end

    // Saturation up then down at index 5, lookup at 0x14 every cycle.
    // First step is the same-cycle lookup/update case.
    step(32'h14, 1'b1, 6'd5, 1'b1, 1'b1, 0, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b0, 1'b1, 1, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b0, 1'b0, 1, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b0, 1'b0, 0, -1, -1);
    step(32'h14, 1'b1, 6'd5, 1'b0, 1'b0, 0, -1, -1);
    step(32'h14, 1'b0, 6'd5, 1'b1, 1'b1, 0, -1, -1);
    // update_valid low: taken/mispredict ignored
    step(32'h14, 1'b0, 6'd5, 1'b1, 1'b1, 0, -1, -1);

    // 3-bit counters in B: five taken saturate at 111, then four not-taken
    for (int i = 0; i < 5; i++) begin
      pc = 32'((9 ^ ghrB) << 2);
      step(pc, 1'b1, 6'd9, 1'b1, 1'b0, -1, (i == 0) ? 0 : 1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      pc = 32'((9 ^ ghrB) << 2);
      step(pc, 1'b1, 6'd9, 1'b0, 1'b0, -1, 1, -1);
    end
    pc = 32'((9 ^ ghrB) << 2);
    step(pc, 1'b0, 6'd9, 1'b0, 1'b0, -1, 0, -1);

    // History T,T,NT,T -> 1101; lookup at pc 0 then indexes 0x0D
    reset_both();
    step(32'h0, 1'b1, 6'd0, 1'b1, 1'b0, -1, -1, 0);
    step(32'h0, 1'b1, 6'd0, 1'b1, 1'b0, -1, -1, 1);
    step(32'h0, 1'b1, 6'd0, 1'b0, 1'b0, -1, -1, 3);
    step(32'h0, 1'b1, 6'd0, 1'b1, 1'b0, -1, -1, 6);
    step(32'h0, 1'b0, 6'd0, 1'b0, 1'b0, -1, -1, 13);

    // Mispredict counter: long run, B reset after update 40000, A saturates
    reset_both();
    for (int i = 1; i <= 65540; i++) begin
      @(negedge clk);
      update_valid      = 1'b1;
      update_mispredict = 1'b1;
      update_taken      = i[0];
      update_index      = i[5:0];
      @(posedge clk);
      #1;
      if (i == 40000) begin
        update_valid = 1'b0;
        chk("mc_a_40000", 32'(mc_a), 32'd40000);
        chk("mc_b_40000", 32'(mc_b), 32'd40000);
        rst_b = 1'b0;
        #1;
        chk("mc_b_async_rst", 32'(mc_b), 32'd0);
        chk("mc_a_no_rst", 32'(mc_a), 32'd40000);
        #1;
        rst_b = 1'b1;
      end
      if (i == 65534) chk("mc_a_65534", 32'(mc_a), 32'hFFFE);
      if (i == 65535) chk("mc_a_65535", 32'(mc_a), 32'hFFFF);
    end
    @(negedge clk);
    update_valid = 1'b0;
    #1;
    chk("mc_a_sat", 32'(mc_a), 32'hFFFF);
    chk("mc_b_final", 32'(mc_b), 32'd25540);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised successor to the single 2-bit predictor: a table of 2^INDEX_BITS saturating counters with configurable counter width and an optional global history register for gshare indexing. It sits beside the fetch stage. Fetch issues a same-cycle lookup on the fetch PC and receives a prediction plus the table index used. The execute stage resolves the branch and writes back the outcome using that index. A saturating mispredict counter is included for performance measurement.

## Interface
- INDEX_BITS, 6, log2 of table entries (64 entries)
- CTR_BITS, 2, counter width in bits, legal range 1..4
- GHR_BITS, 0, global history length. 0 selects bimodal indexing; 1..INDEX_BITS selects gshare
- PC_BITS, 32, PC width; must be at least INDEX_BITS+2
- clk  in  1  single clock; rising edge
- reset  in  1  asynchronous, active-low; asserted when 0
- lookup_pc  in  PC_BITS  fetch PC
- predict_taken  out  1  prediction for lookup_pc; combinational
- predict_index  out  INDEX_BITS  table index used; fetch carries it down the pipe to execute
- update_valid  in  1  a resolved conditional branch is present this cycle
- update_index  in  INDEX_BITS  the predict_index captured at fetch
- update_taken  in  1  resolved direction
- update_mispredict  in  1  execute detected a misprediction
- mispredict_count  out  16  saturating count of updates with update_mispredict=1

## Operation
- Counter reset value: WEAK_NT = 2^(CTR_BITS-1)-1. For CTR_BITS=2 this is 01. GHR resets to 0. mispredict_count resets to 0.
- Index calculation:
  - Bimodal: idx = lookup_pc[INDEX_BITS+1:2]
  - Gshare: idx = lookup_pc[INDEX_BITS+1:2] XOR GHR, with GHR zero-extended to INDEX_BITS
- predict_taken = MSB of ctr[idx]. predict_index = idx.
- Update, when update_valid=1:
  - update_taken=1: ctr[update_index] increments and saturates at 2^CTR_BITS-1
  - update_taken=0: ctr[update_index] decrements and saturates at 0
- GHR update (GHR_BITS>0, update_valid=1 only): GHR <= {GHR[GHR_BITS-2:0], update_taken}. For GHR_BITS=1, GHR <= update_taken. GHR is non-speculative and advances only on resolution.
- mispredict_count increments when update_valid=1 and update_mispredict=1. It holds at 0xFFFF once saturated.
- When update_valid=0, update_taken and update_mispredict are ignored. No state changes.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update counter (no bypass). The new value is visible from the next cycle.
- Lookup in the same cycle as a GHR update: the lookup uses the old GHR.

## Timing
- Lookup has zero latency: predict_taken and predict_index are combinational from lookup_pc, the counter array and GHR.
- Update has one-cycle write latency: the counter, GHR and mispredict_count change at the rising clk edge on which update_valid=1 is sampled.
- Reset asserted at any time, including mid-stream: all counters go to WEAK_NT, GHR and mispredict_count go to 0 immediately and asynchronously. While reset=0, the outputs reflect the reset state. The first update is accepted on the first rising edge after reset returns to 1.
- There is no handshake or backpressure. At most one update is accepted per cycle.

## Structure
- Shared package bp_pkg holds:
  - function ctr_weak_nt(CTR_BITS)
  - function sat_inc / sat_dec (width-generic)
  - constant MISPRED_CNT_BITS = 16
- Sub-module bp_index_hash (combinational): inputs pc and ghr, output idx. It handles the GHR_BITS==0 bypass. It is reused by future tournament and global-history predictors.
- Counter storage is a flop array (the async reset of every entry is required), not inferred RAM.

## Test plan
- Reset with defaults -> every lookup_pc gives predict_taken=0. predict_index=0x05 for lookup_pc=0x14. mispredict_count=0.
- Defaults; three updates taken at index 5, then four not-taken -> lookup at 0x14 predicts 1,1,1 after each taken update, then 1,0,0,0 after each not-taken update. The counter saturates at 11 and then at 00.
- Same-cycle lookup and update, index 5 holding 01, update_taken=1 -> predict_taken=0 in that cycle and 1 in the next cycle.
- GHR_BITS=4; updates taken, taken, not-taken, taken -> GHR=1101. A lookup at pc=0x0 then gives predict_index=0x0D.
- CTR_BITS=3 -> reset value 011. Four taken updates give 111 and hold there. predict_taken goes to 1 after the first taken update.
- 65540 updates with update_mispredict=1, reset asserted mid-run at update 40000 -> count returns to 0 asynchronously, then reaches 25540. A separate run without reset saturates at 0xFFFF.
